// File: rtl/br_pkg.sv
// br_pkg: shared definitions for the branch resolution unit.
//   - funct3 encodings of the six RV32I conditional branches
//   - bht_state_e: 2-bit saturating direction counter states
//   - bht_next(): counter training step (saturating up/down)
package br_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // MSB of the state is the predicted direction.
  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bht_state_e;

  // Saturating counter step: taken moves towards ST, not-taken towards SNT.
  function automatic bht_state_e bht_next(input bht_state_e state, input logic taken);
    bht_state_e nxt;
    nxt = state;
    case (state)
      SNT:     nxt = taken ? WNT : SNT;
      WNT:     nxt = taken ? WT  : SNT;
      WT:      nxt = taken ? ST  : WNT;
      ST:      nxt = taken ? ST  : WT;
      default: nxt = WNT;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/br_cond_eval.sv
// br_cond_eval: combinational branch condition evaluator.
// Ports:
//   a, b     in  XLEN : rs1 / rs2 operand values
//   funct3   in  3    : branch kind (instr[14:12])
//   taken    out 1    : branch condition holds (0 for illegal encodings)
//   illegal  out 1    : funct3 is not a conditional branch (010 / 011)
module br_cond_eval
  import br_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [2:0]      funct3,
  output logic            taken,
  output logic            illegal
);

  // Select the compare named by funct3; anything unrecognised is illegal and never taken.
  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    case (funct3)
      F3_BEQ:  taken = (a == b);
      F3_BNE:  taken = (a != b);
      F3_BLT:  taken = ($signed(a) <  $signed(b));
      F3_BGE:  taken = ($signed(a) >= $signed(b));
      F3_BLTU: taken = (a <  b);
      F3_BGEU: taken = (a >= b);
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/br_resolve_unit.sv
// br_resolve_unit: branch resolution with a 2-bit BHT predictor.
// Ports:
//   clk, rst            in  1    : clock (rising edge), synchronous active-high reset
//   pred_pc / pred_taken in XLEN / out 1 : fetch-time BHT lookup (combinational)
//   in_valid, in_pc, in_target, in_a, in_b, in_funct3, in_pred_taken, flush : branch issue
//   res_valid, res_taken, res_mispredict, res_redirect_pc, res_illegal : registered result,
//                         valid for exactly the cycle after an accepted issue
//   cnt_branches, cnt_mispredicts out CNT_W : saturating performance counters
module br_resolve_unit
  import br_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [XLEN-1:0]  pred_pc,
  output logic             pred_taken,
  input  logic             in_valid,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_target,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [2:0]       in_funct3,
  input  logic             in_pred_taken,
  input  logic             flush,
  output logic             res_valid,
  output logic             res_taken,
  output logic             res_mispredict,
  output logic [XLEN-1:0]  res_redirect_pc,
  output logic             res_illegal,
  output logic [CNT_W-1:0] cnt_branches,
  output logic [CNT_W-1:0] cnt_mispredicts
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  bht_state_e       bht_q [BHT_ENTRIES];
  bht_state_e       bht_d [BHT_ENTRIES];
  logic             res_valid_q, res_valid_d;
  logic             res_taken_q, res_taken_d;
  logic             res_mis_q, res_mis_d;
  logic             res_ill_q, res_ill_d;
  logic [XLEN-1:0]  res_redir_q, res_redir_d;
  logic [CNT_W-1:0] cnt_br_q, cnt_br_d;
  logic [CNT_W-1:0] cnt_mp_q, cnt_mp_d;

  logic             cond_taken_s;
  logic             cond_illegal_s;
  logic             accept_s;
  logic             mispredict_s;
  logic [IDX_W-1:0] in_idx_s;
  logic [IDX_W-1:0] pred_idx_s;

  br_cond_eval #(.XLEN(XLEN)) u_cond (
    .a       (in_a),
    .b       (in_b),
    .funct3  (in_funct3),
    .taken   (cond_taken_s),
    .illegal (cond_illegal_s)
  );

  assign accept_s     = in_valid & ~flush & ~rst;
  assign mispredict_s = ~cond_illegal_s & (cond_taken_s != in_pred_taken);
  assign in_idx_s     = in_pc[IDX_W+1:2];
  assign pred_idx_s   = pred_pc[IDX_W+1:2];

  // Lookup reads the registered array, so a same-cycle update is not forwarded.
  assign pred_taken = bht_q[pred_idx_s][1];

  // Result, BHT training and counter next-state for an accepted issue.
  always_comb begin
    bht_d       = bht_q;
    res_valid_d = 1'b0;
    res_taken_d = 1'b0;
    res_mis_d   = 1'b0;
    res_ill_d   = 1'b0;
    res_redir_d = '0;
    cnt_br_d    = cnt_br_q;
    cnt_mp_d    = cnt_mp_q;
    if (accept_s) begin
      res_valid_d = 1'b1;
      res_taken_d = cond_taken_s;
      res_mis_d   = mispredict_s;
      res_ill_d   = cond_illegal_s;
      res_redir_d = cond_taken_s ? in_target : (in_pc + XLEN'(3'd4));
      if (!cond_illegal_s) begin
        // Read-modify-write on the current array value: back-to-back hits chain correctly.
        bht_d[in_idx_s] = bht_next(bht_q[in_idx_s], cond_taken_s);
        if (cnt_br_q != {CNT_W{1'b1}}) begin
          cnt_br_d = cnt_br_q + CNT_W'(1'b1);
        end else begin
          cnt_br_d = cnt_br_q;
        end
        if (mispredict_s && (cnt_mp_q != {CNT_W{1'b1}})) begin
          cnt_mp_d = cnt_mp_q + CNT_W'(1'b1);
        end else begin
          cnt_mp_d = cnt_mp_q;
        end
      end else begin
        cnt_br_d = cnt_br_q;
      end
    end else begin
      res_valid_d = 1'b0;
    end
  end

  // State registers; reset returns every BHT entry to weakly-not-taken in one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        bht_q[i] <= WNT;
      end
      res_valid_q <= 1'b0;
      res_taken_q <= 1'b0;
      res_mis_q   <= 1'b0;
      res_ill_q   <= 1'b0;
      res_redir_q <= '0;
      cnt_br_q    <= '0;
      cnt_mp_q    <= '0;
    end else begin
      bht_q       <= bht_d;
      res_valid_q <= res_valid_d;
      res_taken_q <= res_taken_d;
      res_mis_q   <= res_mis_d;
      res_ill_q   <= res_ill_d;
      res_redir_q <= res_redir_d;
      cnt_br_q    <= cnt_br_d;
      cnt_mp_q    <= cnt_mp_d;
    end
  end

  assign res_valid       = res_valid_q;
  assign res_taken       = res_taken_q;
  assign res_mispredict  = res_mis_q;
  assign res_illegal     = res_ill_q;
  assign res_redirect_pc = res_redir_q;
  assign cnt_branches    = cnt_br_q;
  assign cnt_mispredicts = cnt_mp_q;

endmodule

// File: tb/tb_br_resolve_unit.sv
// Scoreboard bench for br_resolve_unit: the driver pushes expected results
// from a behavioural model; a negedge monitor pops and compares.
// A second instance with 4-bit counters shares the inputs to exercise saturation.
module tb_br_resolve_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pred_pc;
  logic        in_valid, in_pred_taken, flush;
  logic [31:0] in_pc, in_target, in_a, in_b;
  logic [2:0]  in_funct3;

  logic        pred_taken, res_valid, res_taken, res_mispredict, res_illegal;
  logic [31:0] res_redirect_pc, cnt_branches, cnt_mispredicts;

  logic        s_pred_taken, s_res_valid, s_res_taken, s_res_mispredict, s_res_illegal;
  logic [31:0] s_res_redirect_pc;
  logic [3:0]  s_cnt_branches, s_cnt_mispredicts;

  always #5 clk = ~clk;

  br_resolve_unit #(.XLEN(32), .BHT_ENTRIES(64), .CNT_W(32)) u_dut (
    .clk(clk), .rst(rst), .pred_pc(pred_pc), .pred_taken(pred_taken),
    .in_valid(in_valid), .in_pc(in_pc), .in_target(in_target), .in_a(in_a), .in_b(in_b),
    .in_funct3(in_funct3), .in_pred_taken(in_pred_taken), .flush(flush),
    .res_valid(res_valid), .res_taken(res_taken), .res_mispredict(res_mispredict),
    .res_redirect_pc(res_redirect_pc), .res_illegal(res_illegal),
    .cnt_branches(cnt_branches), .cnt_mispredicts(cnt_mispredicts)
  );

  br_resolve_unit #(.XLEN(32), .BHT_ENTRIES(64), .CNT_W(4)) u_small (
    .clk(clk), .rst(rst), .pred_pc(pred_pc), .pred_taken(s_pred_taken),
    .in_valid(in_valid), .in_pc(in_pc), .in_target(in_target), .in_a(in_a), .in_b(in_b),
    .in_funct3(in_funct3), .in_pred_taken(in_pred_taken), .flush(flush),
    .res_valid(s_res_valid), .res_taken(s_res_taken), .res_mispredict(s_res_mispredict),
    .res_redirect_pc(s_res_redirect_pc), .res_illegal(s_res_illegal),
    .cnt_branches(s_cnt_branches), .cnt_mispredicts(s_cnt_mispredicts)
  );

  typedef struct {
    bit          taken;
    bit          mis;
    bit          ill;
    logic [31:0] redir;
  } exp_t;

  exp_t    exp_q[$];
  exp_t    mon_e;
  int      checks   = 0;
  int      failures = 0;
  bit      mon_en   = 1'b0;
  int      bht_m[64];
  longint  m_br, m_mp;
  int      s_br, s_mp;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 64; i++) bht_m[i] = 1;
    m_br = 0; m_mp = 0; s_br = 0; s_mp = 0;
  endfunction

  // Reference semantics straight from the branch table.
  function automatic void ref_eval(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                   output bit taken, output bit ill);
    int sa, sb;
    sa = int'(a); sb = int'(b);
    ill = 1'b0; taken = 1'b0;
    case (f3)
      3'd0: taken = (a == b);
      3'd1: taken = (a != b);
      3'd4: taken = (sa < sb);
      3'd5: taken = (sa >= sb);
      3'd6: taken = (a < b);
      3'd7: taken = (a >= b);
      default: ill = 1'b1;
    endcase
  endfunction

  // One cycle of stimulus; model advances at the same edge as the DUT.
  task automatic step(input bit v, input logic [31:0] pc, input logic [31:0] tgt,
                      input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3,
                      input bit pt, input bit fl, input bit r, input logic [31:0] ppc);
    exp_t e;
    bit   tk, il;
    int   idx;
    in_valid = v; in_pc = pc; in_target = tgt; in_a = a; in_b = b;
    in_funct3 = f3; in_pred_taken = pt; flush = fl; rst = r; pred_pc = ppc;
    #1;
    if (mon_en) chk("pred_taken", {63'd0, pred_taken}, {63'd0, bht_m[ppc[7:2]] >= 2});
    @(posedge clk);
    if (r) begin
      model_reset();
      exp_q.delete();
    end else if (v && !fl) begin
      ref_eval(f3, a, b, tk, il);
      e.taken = tk;
      e.ill   = il;
      e.mis   = !il && (tk != pt);
      e.redir = tk ? tgt : pc + 32'd4;
      exp_q.push_back(e);
      if (!il) begin
        idx = int'(pc[7:2]);
        if (tk) bht_m[idx] = (bht_m[idx] < 3) ? bht_m[idx] + 1 : 3;
        else    bht_m[idx] = (bht_m[idx] > 0) ? bht_m[idx] - 1 : 0;
        if (m_br < 64'hFFFF_FFFF) m_br++;
        if (s_br < 15) s_br++;
        if (e.mis) begin
          if (m_mp < 64'hFFFF_FFFF) m_mp++;
          if (s_mp < 15) s_mp++;
        end
      end
    end
    #1;
    if (r && mon_en) begin
      chk("rst_res_valid", res_valid, 0);
      chk("rst_res_taken", res_taken, 0);
      chk("rst_res_mispredict", res_mispredict, 0);
      chk("rst_res_illegal", res_illegal, 0);
      chk("rst_res_redirect_pc", res_redirect_pc, 0);
      chk("rst_cnt_branches", cnt_branches, 0);
      chk("rst_cnt_mispredicts", cnt_mispredicts, 0);
    end
  endtask

  task automatic idle(input logic [31:0] ppc);
    step(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 3'd0, 1'b0, 1'b0, 1'b0, ppc);
  endtask

  // Monitor: pop on every result, flag results that are missing or unexpected.
  always @(negedge clk) begin
    if (mon_en) begin
      if (res_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("res_valid_unexpected", res_valid, 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("res_taken", res_taken, mon_e.taken);
          chk("res_mispredict", res_mispredict, mon_e.mis);
          chk("res_illegal", res_illegal, mon_e.ill);
          chk("res_redirect_pc", res_redirect_pc, mon_e.redir);
        end
      end else if (exp_q.size() != 0) begin
        chk("res_valid_missing", res_valid, 1);
        mon_e = exp_q.pop_front();
      end
      chk("cnt_branches", cnt_branches, m_br);
      chk("cnt_mispredicts", cnt_mispredicts, m_mp);
      chk("small_cnt_branches", s_cnt_branches, s_br);
      chk("small_cnt_mispredicts", s_cnt_mispredicts, s_mp);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    step(1'b1, 32'h40, 32'h80, 32'd1, 32'd1, 3'd0, 1'b0, 1'b0, 1'b1, 32'h123);
    step(1'b0, 32'h0, 32'h0, 32'd0, 32'd0, 3'd0, 1'b0, 1'b0, 1'b1, 32'h0);
    mon_en = 1'b1;
    idle(32'h0000_0abc);
    idle(32'hffff_fffc);
    // BEQ taken, predicted not-taken: mispredict to target.
    step(1'b1, 32'h200, 32'h300, 32'd5, 32'd5, 3'd0, 1'b0, 1'b0, 1'b0, 32'h200);
    // Signed vs unsigned compares, then >= with equal operands.
    step(1'b1, 32'h204, 32'h400, 32'hFFFF_FFFF, 32'd1, 3'd4, 1'b1, 1'b0, 1'b0, 32'h204);
    step(1'b1, 32'h208, 32'h500, 32'hFFFF_FFFF, 32'd1, 3'd6, 1'b1, 1'b0, 1'b0, 32'h208);
    step(1'b1, 32'h20c, 32'h600, 32'd7, 32'd7, 3'd5, 1'b0, 1'b0, 1'b0, 32'h20c);
    step(1'b1, 32'h210, 32'h700, 32'd7, 32'd7, 3'd7, 1'b1, 1'b0, 1'b0, 32'h210);
    // Train index of 0x100 up to saturation, then back down to SNT.
    for (int i = 0; i < 3; i++)
      step(1'b1, 32'h100, 32'h180, 32'd3, 32'd3, 3'd0, 1'b1, 1'b0, 1'b0, 32'h100);
    for (int i = 0; i < 3; i++)
      step(1'b1, 32'h100, 32'h180, 32'd3, 32'd3, 3'd1, 1'b0, 1'b0, 1'b0, 32'h100);
    idle(32'h100);
    // Alias 0x100 + 4*64: training it moves the prediction of 0x100.
    for (int i = 0; i < 3; i++)
      step(1'b1, 32'h100 + 32'd256, 32'h900, 32'd1, 32'd2, 3'd6, 1'b0, 1'b0, 1'b0, 32'h100);
    idle(32'h100);
    // Illegal encodings and a flushed issue.
    step(1'b1, 32'h100, 32'h180, 32'd3, 32'd3, 3'd2, 1'b1, 1'b0, 1'b0, 32'h100);
    step(1'b1, 32'h100, 32'h180, 32'd3, 32'd4, 3'd3, 1'b0, 1'b0, 1'b0, 32'h100);
    step(1'b1, 32'h100, 32'h180, 32'd3, 32'd3, 3'd0, 1'b0, 1'b1, 1'b0, 32'h100);
    idle(32'h100);
    // 20 branches drive the 4-bit counters into saturation.
    for (int i = 0; i < 20; i++)
      step(1'b1, 32'h300 + 32'(i * 4), 32'h1000, 32'(i), 32'd10, 3'd4, i[0], 1'b0, 1'b0, 32'h300);
    // Reset in the middle of a stream: in-flight result dropped, BHT back to WNT.
    step(1'b1, 32'h100, 32'h180, 32'd3, 32'd3, 3'd0, 1'b0, 1'b0, 1'b0, 32'h100);
    step(1'b1, 32'h104, 32'h180, 32'd3, 32'd3, 3'd0, 1'b0, 1'b0, 1'b1, 32'h104);
    idle(32'h340);
    idle(32'h104);
    // Randomised traffic with occasional flush and reset.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] ra, rb, rpc;
      ra  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      rb  = ($urandom_range(0, 2) == 0) ? ra : (($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 3)) : $urandom);
      rpc = ($urandom & 32'h0000_07FC);
      step(($urandom_range(0, 4) != 0), rpc, $urandom & 32'hFFFF_FFFC, ra, rb,
           3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 15) == 0), ($urandom_range(0, 99) == 0),
           ($urandom_range(0, 1) == 0) ? rpc : ($urandom & 32'h0000_07FC));
    end
    idle(32'h0);
    idle(32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
